// File: rtl/sram_client_pkg.sv
// Shared types and constants for the SRAM client port and its grant counter.
package sram_client_pkg;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;

  localparam logic [SRAM_DW-1:0] ABORT_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_grant_ctr.sv
// Consecutive-grant counter for one SRAM client port; with SRAM_CLIENT_TIMEOUT_EN
// defined it also counts stall edges and raises abort after MAX_STALL of them.
module sram_grant_ctr
  import sram_client_pkg::*;
#(
  parameter int EN_CYCLES = 2,
  parameter int MAX_STALL = 255
) (
  input  logic clka,
  input  logic rst_n,
  input  logic start_i,
  input  logic active_i,
  input  logic hp_busy_i,
  output logic done_o,
  output logic abort_o
);

  localparam int            GW     = $clog2(EN_CYCLES + 1);
  localparam logic [GW-1:0] G_MAX  = GW'(EN_CYCLES);
  localparam logic [GW-1:0] G_LAST = GW'(EN_CYCLES - 1);
  localparam logic [GW-1:0] G_ONE  = GW'(1);

  if (EN_CYCLES < 1 || MAX_STALL < 1 || MAX_STALL > 255) begin : g_bad_param
    $error("sram_grant_ctr: EN_CYCLES must be >= 1 and MAX_STALL within 1..255");
  end

  logic [GW-1:0] gcnt_q, gcnt_d;

  // A stall breaks the run: the strobe must see EN_CYCLES serviced edges in a row.
  always_comb begin
    gcnt_d = gcnt_q;
    if (start_i) begin
      gcnt_d = '0;
    end else if (active_i) begin
      if (hp_busy_i)            gcnt_d = '0;
      else if (gcnt_q != G_MAX) gcnt_d = gcnt_q + G_ONE;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign done_o = active_i && !hp_busy_i && (gcnt_q == G_LAST);

`ifdef SRAM_CLIENT_TIMEOUT_EN
  localparam logic [7:0] S_LAST = 8'(MAX_STALL - 1);

  logic [7:0] scnt_q, scnt_d;

  always_comb begin
    scnt_d = scnt_q;
    if (start_i) begin
      scnt_d = '0;
    end else if (active_i && hp_busy_i && scnt_q != 8'hFF) begin
      scnt_d = scnt_q + 8'd1;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end

  assign abort_o = active_i && hp_busy_i && (scnt_q == S_LAST);
`else
  assign abort_o = 1'b0;
`endif

endmodule

// File: rtl/sram_client_port.sv
// Requester-side front end for one port of the shared external-SRAM arbiter.
// Optional stall timeout is enabled by defining SRAM_CLIENT_TIMEOUT_EN.
module sram_client_port
  import sram_client_pkg::*;
#(
  parameter int EN_CYCLES = 2,
  parameter int MAX_STALL = 255
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [SRAM_AW-1:0] req_addr,
  input  logic [SRAM_DW-1:0] req_wdata,
  output logic               rsp_rvalid,
  output logic               rsp_wdone,
  output logic [SRAM_DW-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               sram_en,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_din,
  input  logic [SRAM_DW-1:0] sram_dout,
  input  logic               hp_busy
);

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic               we_q, we_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] din_q, din_d;
  logic               rvalid_q, rvalid_d;
  logic               wdone_q, wdone_d;
  logic [SRAM_DW-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               accept, done, abort;

  assign accept = (state_q == IDLE) && req_valid;

  sram_grant_ctr #(
    .EN_CYCLES (EN_CYCLES),
    .MAX_STALL (MAX_STALL)
  ) u_grant_ctr (
    .clka      (clka),
    .rst_n     (rst_n),
    .start_i   (accept),
    .active_i  (state_q == ISSUE),
    .hp_busy_i (hp_busy),
    .done_o    (done),
    .abort_o   (abort)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ISSUE;
          en_d    = 1'b1;
          we_d    = req_we;
          addr_d  = req_addr;
          din_d   = req_wdata;
        end
      end
      ISSUE: begin
        // we_q still identifies the transaction type on the closing edge.
        if (abort) begin
          state_d = IDLE;
          en_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          if (we_q) begin
            wdone_d = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = ABORT_RDATA;
          end
        end else if (done) begin
          en_d = 1'b0;
          we_d = 1'b0;
          if (we_q) begin
            state_d = IDLE;
            wdone_d = 1'b1;
          end else begin
            state_d = CAPT;
          end
        end
      end
      CAPT: begin
        state_d  = IDLE;
        rdata_d  = sram_dout;
        rvalid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign sram_en    = en_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
  assign rsp_rvalid = rvalid_q;
  assign rsp_wdone  = wdone_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_sram_client_port.sv
// Randomized bench for sram_client_port against a transaction-level reference model.
module tb_sram_client_port;

  localparam int EN_CYCLES = 2;
`ifdef SRAM_CLIENT_TIMEOUT_EN
  localparam int DUT_MAX_STALL = 4;
  localparam int TB_MAX_STALL  = 4;
`else
  localparam int DUT_MAX_STALL = 255;
  localparam int TB_MAX_STALL  = 0;
`endif

  logic        clka = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [18:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_rvalid, rsp_wdone, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        sram_en, sram_we;
  logic [18:0] sram_addr;
  logic [7:0]  sram_din, sram_dout;
  logic        hp_busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_rdata = 8'h00;

  always #5 clka = ~clka;

  sram_client_port #(
    .EN_CYCLES (EN_CYCLES),
    .MAX_STALL (DUT_MAX_STALL)
  ) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_rvalid (rsp_rvalid),
    .rsp_wdone  (rsp_wdone),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .hp_busy    (hp_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic junk_req();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = 19'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Idle cycles: nothing in flight, no pulses, read data held.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = 1'b0;
      hp_busy   = 1'($urandom);
      sram_dout = 8'($urandom);
      @(negedge clka);
      chk("idle_en", sram_en, 1'b0);
      chk("idle_ready", req_ready, 1'b1);
      chk("idle_rvalid", rsp_rvalid, 1'b0);
      chk("idle_wdone", rsp_wdone, 1'b0);
      chk("idle_rdata", rsp_rdata, exp_rdata);
    end
  endtask

  // One transaction, entered and left at a negedge with the port idle.
  // The model: the strobe ends on the first edge closing EN_CYCLES consecutive
  // un-stalled edges, or (timeout build) on the MAX_STALL-th stall edge.
  task automatic do_txn(input bit we, input logic [18:0] addr, input logic [7:0] wdata,
                        input logic [7:0] dout, input bit use_pat, input logic [31:0] pat);
    bit h[$];
    int stalls;
    bit fin, abrt, hp, clean;
    chk("accept_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    hp_busy   = 1'($urandom);
    sram_dout = 8'($urandom);
    stalls = 0;
    fin    = 1'b0;
    abrt   = 1'b0;
    for (int i = 1; i <= 64 && !fin; i++) begin
      @(negedge clka);
      chk("en_held", sram_en, 1'b1);
      chk("addr_stable", sram_addr, addr);
      chk("we_held", sram_we, we);
      chk("din_stable", sram_din, wdata);
      chk("busy_ready", req_ready, 1'b0);
      chk("busy_rvalid", rsp_rvalid, 1'b0);
      chk("busy_wdone", rsp_wdone, 1'b0);
      chk("busy_rdata", rsp_rdata, exp_rdata);
      junk_req();
      if (use_pat) hp = (i <= 32) ? pat[i-1] : 1'b0;
      else         hp = ($urandom_range(0, 2) == 0);
      if (i > 40) hp = 1'b0;
      hp_busy   = hp;
      sram_dout = 8'($urandom);
      h.push_back(hp);
      if (hp) begin
        stalls++;
        if (TB_MAX_STALL > 0 && stalls == TB_MAX_STALL) begin
          abrt = 1'b1;
          fin  = 1'b1;
        end
      end else if (h.size() >= EN_CYCLES) begin
        clean = 1'b1;
        for (int k = h.size() - EN_CYCLES; k < h.size(); k++) if (h[k]) clean = 1'b0;
        if (clean) fin = 1'b1;
      end
    end
    @(negedge clka);
    chk("en_drop", sram_en, 1'b0);
    if (!abrt) chk("we_drop", sram_we, 1'b0);
    if (we || abrt) begin
      if (!we) exp_rdata = 8'hFF;
      chk("rsp_wdone", rsp_wdone, we);
      chk("rsp_rvalid", rsp_rvalid, !we);
      chk("rsp_err", rsp_err, abrt);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("done_ready", req_ready, 1'b1);
    end else begin
      chk("capt_rvalid", rsp_rvalid, 1'b0);
      chk("capt_wdone", rsp_wdone, 1'b0);
      chk("capt_ready", req_ready, 1'b0);
      junk_req();
      hp_busy   = 1'($urandom);
      sram_dout = dout;
      @(negedge clka);
      exp_rdata = dout;
      chk("rsp_rvalid", rsp_rvalid, 1'b1);
      chk("rsp_wdone", rsp_wdone, 1'b0);
      chk("rsp_err", rsp_err, 1'b0);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("done_ready", req_ready, 1'b1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    sram_dout = '0;
    hp_busy   = 1'b0;
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_en", sram_en, 1'b0);
    chk("rst_we", sram_we, 1'b0);
    chk("rst_addr", sram_addr, 19'h0);
    chk("rst_din", sram_din, 8'h0);
    chk("rst_rvalid", rsp_rvalid, 1'b0);
    chk("rst_wdone", rsp_wdone, 1'b0);
    chk("rst_rdata", rsp_rdata, 8'h0);
    chk("rst_err", rsp_err, 1'b0);
    @(negedge clka);
    rst_n = 1'b1;
    idle(2);

    // Directed: plain read, max-address write, stalled read, back-to-back reads.
    do_txn(1'b0, 19'h0F000, 8'h00, 8'h5A, 1'b1, 32'h0);
    idle(1);
    do_txn(1'b1, 19'h7FFFF, 8'hC3, 8'h00, 1'b1, 32'h0);
    idle(1);
    do_txn(1'b0, 19'h12345, 8'h00, 8'hA7, 1'b1, 32'b0010);
    idle(1);
    do_txn(1'b0, 19'h00010, 8'h00, 8'h11, 1'b1, 32'h0);
    do_txn(1'b0, 19'h00011, 8'h00, 8'hEE, 1'b1, 32'h0);
    do_txn(1'b1, 19'h00012, 8'h3C, 8'h00, 1'b1, 32'h0);
    do_txn(1'b1, 19'h00013, 8'h96, 8'h00, 1'b1, 32'h0);
    idle(1);
`ifdef SRAM_CLIENT_TIMEOUT_EN
    do_txn(1'b0, 19'h2AAAA, 8'h00, 8'h5A, 1'b1, 32'hFFFF_FFFF);
    idle(1);
    do_txn(1'b1, 19'h15555, 8'h77, 8'h00, 1'b1, 32'hFFFF_FFFF);
    idle(1);
`endif

    for (int t = 0; t < 150; t++) begin
      do_txn(1'($urandom), 19'($urandom), 8'($urandom), 8'($urandom), 1'b0, 32'h0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a stalled read.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 19'h0ABCD;
    hp_busy   = 1'b1;
    @(negedge clka);
    chk("pre_rst_en", sram_en, 1'b1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_en", sram_en, 1'b0);
    chk("async_rst_ready", req_ready, 1'b1);
    chk("async_rst_rvalid", rsp_rvalid, 1'b0);
    @(negedge clka);
    rst_n     = 1'b1;
    hp_busy   = 1'b0;
    exp_rdata = 8'h00;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
